jtopl_acc_seq: RTL

JTOPL_ACC_SEQ -- requirements
Module: jtopl_acc_seq

---
 rtl/jtopl_pkg.sv | 25 ++
 rtl/jtopl_sh_cen.sv | 23 ++
 rtl/jtopl_acc_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/jtopl_pkg.sv
// jtopl_pkg: frame geometry and slot decode helpers shared by the operator sequencer and accumulator.
package jtopl_pkg;
    localparam int SLOTS    = 18;
    localparam int CHANNELS = 9;
    localparam int GROUP    = 3;

    typedef struct packed {
        logic rhy;
        logic zero;
        logic con;
        logic op;
    } acc_tag_t;

    function automatic logic issue_op(input logic [4:0] cnt);
        logic [4:0] g;
        g = cnt / 5'(GROUP);
        return g[0];
    endfunction

    function automatic logic [3:0] issue_ch(input logic [4:0] cnt);
        logic [4:0] ch;
        ch = 5'(GROUP) * (cnt / 5'(2 * GROUP)) + cnt % 5'(GROUP);
        return ch[3:0];
    endfunction
endpackage

// File: rtl/jtopl_sh_cen.sv
// jtopl_sh_cen: clock-enabled shift register; nxt is the value the last stage loads on the next enable.
module jtopl_sh_cen #(
    parameter int width  = 1,
    parameter int stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [width-1:0] nxt
);
    logic [stages-1:0][width-1:0] sh;
    logic [stages:0][width-1:0]   tp;

    assign tp   = {sh, din};
    assign dout = tp[stages];
    assign nxt  = tp[stages-1];

    always_ff @(posedge clk)
        if (rst)      sh <= '0;
        else if (cen) sh <= tp[stages-1:0];
endmodule

// File: rtl/jtopl_acc_seq.sv
// jtopl_acc_seq: operator slot sequencer for the accumulator; issues slots, aligns op/con/zero
// to op_result latency, and latches the completed frame sum.
module jtopl_acc_seq
    import jtopl_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cenop,
    input  logic [8:0]         con_reg,
    input  logic               rhy_reg,
    input  logic signed [15:0] snd_in,
    output logic [SLOTS-1:0]   slot,
    output logic               op,
    output logic               con,
    output logic               zero,
    output logic               rhy_en,
    output logic signed [15:0] snd_out,
    output logic               snd_valid
);
    logic [4:0]          cnt, cnt_nxt;
    logic [CHANNELS-1:0] con_snap, con_src;
    logic                rhy_snap, armed;
    acc_tag_t            tag_in, tag_out, tag_nxt;

    // Slot 0 issues in the same cenop that takes the snapshot, so it sees the live registers.
    always_comb begin
        con_src = cnt == 5'd0 ? con_reg : con_snap;
        cnt_nxt = cnt == 5'(SLOTS - 1) ? 5'd0 : cnt + 5'd1;
        tag_in  = '{rhy:  cnt == 5'd0 ? rhy_reg : rhy_snap,
                    zero: cnt == 5'd0,
                    con:  issue_op(cnt) & con_src[issue_ch(cnt)],
                    op:   issue_op(cnt)};
    end

    jtopl_sh_cen #(.width($bits(acc_tag_t)), .stages(LAT)) u_dly (
        .clk  (clk),
        .rst  (rst),
        .cen  (cenop),
        .din  (tag_in),
        .dout (tag_out),
        .nxt  (tag_nxt)
    );

    assign op   = tag_out.op;
    assign con  = tag_out.con;
    assign zero = tag_out.zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            slot      <= SLOTS'(1);
            con_snap  <= '0;
            rhy_snap  <= 1'b0;
            rhy_en    <= 1'b0;
            snd_out   <= '0;
            snd_valid <= 1'b0;
            armed     <= 1'b0;
        end else begin
            snd_valid <= 1'b0;
            if (cenop) begin
                cnt  <= cnt_nxt;
                slot <= SLOTS'(1) << cnt_nxt;
                if (cnt == 5'd0) begin
                    con_snap <= con_reg;
                    rhy_snap <= rhy_reg;
                end
                if (tag_nxt.zero) rhy_en <= tag_nxt.rhy;
                // The first frame after reset is incomplete, so its sum is discarded.
                if (zero) begin
                    armed <= 1'b1;
                    if (armed) begin
                        snd_out   <= snd_in;
                        snd_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
